// File: rtl/mips_io_pkg.sv
// Shared definitions for memory-mapped I/O peripherals on the MIPS data bus:
// UART transmitter state encoding, STATUS bit positions and register offsets.
package mips_io_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_BUSY_BIT  = 2;
   localparam int STAT_OVF_BIT   = 3;
   localparam int STAT_COUNT_LSB = 8;

   localparam logic [31:0] TXDATA_OFS = 32'd0;
   localparam logic [31:0] STATUS_OFS = 32'd4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers; the extra pointer MSB tells
// a full FIFO apart from an empty one. Callers must not pop when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

   assign dout  = mem_q[rd_ptr_q[AW-1:0]];
   assign count = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes in a FIFO,
// loads from STATUS report FIFO level, busy and a sticky overflow flag.
module uart_tx_mmio
   import mips_io_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 5208,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [31:0] BASE_ADDR    = 32'h1001_0024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        TxSerial,
   output logic        TxBusy
);

   localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
   localparam int            BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   logic          wr_hit, st_hit;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          baud_wrap;
   logic          unused_wdata;

   tx_state_e     state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          overflow_q, overflow_d;

   assign wr_hit       = MemWrite && (Address == BASE_ADDR + TXDATA_OFS);
   assign st_hit       = MemRead && (Address == BASE_ADDR + STATUS_OFS);
   assign fifo_pop     = (state_q == ST_IDLE) && !fifo_empty;
   // A full FIFO still accepts a byte when the transmitter frees a slot on the same edge.
   assign fifo_push    = wr_hit && (!fifo_full || fifo_pop);
   assign unused_wdata = ^WriteData[31:8];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (WriteData[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      ReadData = '0;
      if (st_hit) begin
         ReadData[STAT_COUNT_LSB +: CW] = fifo_count;
         ReadData[STAT_OVF_BIT]         = overflow_q;
         ReadData[STAT_BUSY_BIT]        = TxBusy;
         ReadData[STAT_EMPTY_BIT]       = fifo_empty;
         ReadData[STAT_FULL_BIT]        = fifo_full;
      end
   end

   always_comb begin
      overflow_d = overflow_q;
      if (st_hit)                overflow_d = 1'b0;
      if (wr_hit && !fifo_push)  overflow_d = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      tx_d      = 1'b1;
      baud_wrap = (baud_q == BAUD_LAST);
      if (state_q != ST_IDLE) baud_d = baud_wrap ? '0 : baud_q + 1'b1;
      case (state_q)
         ST_IDLE: if (fifo_pop) begin
            shift_d = fifo_dout;
            baud_d  = '0;
            bit_d   = '0;
            state_d = ST_START;
         end
         ST_START: if (baud_wrap) state_d = ST_DATA;
         ST_DATA: if (baud_wrap) begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = ST_STOP;
         end
         ST_STOP: if (baud_wrap) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Line level follows the next state so the start bit appears right after the pop edge.
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   assign TxSerial = tx_q;
   assign TxBusy   = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the single-cycle MIPS data bus, next to `DataMemory`, and it consumes the processor's store traffic. A `sw` to the TXDATA address pushes the low byte into a small FIFO. An internal FSM serialises each byte as 8N1 on `TxSerial`. A `lw` from STATUS lets software poll for FIFO space and overflow.

## Interface
- `CLKS_PER_BIT`, 5208: clock cycles per bit period (50 MHz / 9600 baud). Must be ≥ 2.
- `FIFO_DEPTH`, 4: byte entries. Must be a power of two, ≥ 2.
- `BASE_ADDR`, 32'h1001_0024: byte address of TXDATA. STATUS is at `BASE_ADDR+4`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Address`  in  32  ALU result (byte address).
- `WriteData`  in  32  store data; only [7:0] is used.
- `MemWrite`  in  1  store strobe from Control.
- `MemRead`  in  1  load strobe from Control.
- `ReadData`  out  32  register read data, combinational.
- `TxSerial`  out  1  serial line, idle high, registered.
- `TxBusy`  out  1  high whenever the FSM is not IDLE.

## Operation
- Decode uses the full 32-bit compare.
  - `wr_hit = MemWrite & Address==BASE_ADDR`.
  - `st_hit = MemRead & Address==BASE_ADDR+4`.
  - No other address has any effect.
- TXDATA is write-only.
  - On `wr_hit` with the FIFO not full, `WriteData[7:0]` is pushed.
  - On `wr_hit` with the FIFO full, the byte is dropped and `overflow` is set.
  - If a pop happens on the same edge, the push is accepted.
- STATUS read gives `ReadData` = {21'b0, count[2:0] at [10:8], 4'b0, overflow[3], busy[2], empty[1], full[0]}.
  - The count field is `$clog2(FIFO_DEPTH)+1` bits wide, zero-extended.
  - `ReadData` is 0 when `st_hit` is low, including reads of TXDATA.
- `overflow` is sticky.
  - It clears on the edge ending a cycle with `st_hit`.
  - If a dropped write occurs in that same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..CLKS_PER_BIT-1 and a bit index runs 0..7.
  - IDLE & FIFO non-empty: pop into the shift register, clear counters, go to START.
  - START: `TxSerial`=0. At counter wrap, go to DATA.
  - DATA: `TxSerial`=shift[0], LSB first. At counter wrap, shift right. After index 7 wraps, go to STOP.
  - STOP: `TxSerial`=1. At counter wrap, go to IDLE.
- There is no bypass: a write to an empty FIFO still goes through the FIFO.

## Timing
- Reset values (asynchronous): `TxSerial`=1, `TxBusy`=0, FIFO empty, count=0, overflow=0, state IDLE, counters 0. STATUS therefore reads 32'h0000_0002.
- Reset asserted mid-frame aborts the frame: the line goes high immediately and queued bytes are discarded.
- Write-to-line latency:
  - Write captured at edge k into an idle, empty block: pop and START occur at edge k+1.
  - `TxSerial` falls after edge k+1.
- Frame length: exactly 10·CLKS_PER_BIT cycles low-start to end-of-stop.
- Gap between back-to-back frames: one IDLE cycle, so consecutive frames start 10·CLKS_PER_BIT+1 cycles apart.
- FIFO flags and count are registered and update on the push/pop edge. STATUS reflects them in the following cycle.

## Structure
- Shared package `mips_io_pkg` holds:
  - the FSM state encoding (2-bit),
  - the STATUS bit-index constants,
  - the TXDATA/STATUS offset constants (0, 4).
- Sub-module `sync_fifo`:
  - parameters `WIDTH`=8 and `DEPTH`;
  - ports push/pop/din/dout/full/empty/count;
  - wrap-around read and write pointers with an extra MSB for the full/empty distinction.
- `uart_tx_mmio` contains the address decode, the overflow flag, the FSM, the baud/bit counters and the shift register.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Reset: hold `reset` 3 cycles, release.
  - → `TxSerial`=1, `TxBusy`=0.
  - → STATUS reads 32'h0000_0002.
- Single byte: `sw` 32'hFFFF_FF55 to BASE_ADDR.
  - → Starting 1 cycle after the write edge, `TxSerial` is 0 for 4 cycles.
  - → Then the bits 1,0,1,0,1,0,1,0 follow, 4 cycles each.
  - → Then 1 for 4 cycles.
  - → `TxBusy` is high for exactly 40 cycles.
- Overflow: six consecutive write cycles of 8'h01..8'h06.
  - → 8'h06 is dropped.
  - → STATUS reads full=1, count=4, overflow=1.
  - → Bytes 01,02,03,04,05 appear in order, each start 41 cycles apart.
- Sticky clear: two consecutive STATUS reads after overflow.
  - → The first read shows bit3=1; the second shows bit3=0.
  - → A dropped write coinciding with a read leaves bit3=1 on the next read.
- Reset mid-frame: assert `reset` during DATA bit 3 of a byte with 2 bytes queued.
  - → `TxSerial`=1 immediately.
  - → After release, STATUS reads 32'h0000_0002 and there is no further line activity.
- Decode isolation:
  - `sw` to BASE_ADDR+4, BASE_ADDR-4 and 32'h1001_0000 → no push, count stays 0.
  - `lw` from BASE_ADDR → `ReadData`=0.
